// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART processor-side bus controller.
// Address map, access FSM states and the reset baud divisor live here.
package spart_pkg;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd325;
    localparam logic [3:0]  FIFO_DEPTH        = 4'd8;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'b00,
        ADDR_STATUS = 2'b01,
        ADDR_DBL    = 2'b10,
        ADDR_DBH    = 2'b11
    } ioaddr_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } bus_state_t;

    // Free TX slots reported in the status register's upper nibble.
    function automatic logic [3:0] calc_tx_free(input logic [3:0] cnt);
        return FIFO_DEPTH - cnt;
    endfunction

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// Host-side chip-select bus of the SPART controller.
// The host is the master; the controller is the slave and owns the read path.
interface spart_bus_if #(
    parameter int DATA_W = 8
);
    logic              iocs;
    logic              iorw;
    logic [1:0]        ioaddr;
    logic [DATA_W-1:0] databus_in;
    logic [DATA_W-1:0] databus_out;
    logic              databus_oe;

    modport master (
        output iocs, iorw, ioaddr, databus_in,
        input  databus_out, databus_oe
    );

    modport slave (
        input  iocs, iorw, ioaddr, databus_in,
        output databus_out, databus_oe
    );
endinterface

// File: rtl/spart_baud_gen.sv
// 16x-oversample baud strobe: down-counter reloaded from the divisor,
// one-cycle baud_en per divisor+1 clocks; a divisor load restarts the period.
module spart_baud_gen #(
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        load,
    output logic        baud_en
);

    logic [15:0] cnt_r;

    // Counter and strobe; a load in the same cycle as terminal count suppresses the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= DIV_RESET;
            baud_en <= 1'b0;
        end else if (load) begin
            cnt_r   <= divisor;
            baud_en <= 1'b0;
        end else if (cnt_r == 16'd0) begin
            cnt_r   <= divisor;
            baud_en <= 1'b1;
        end else begin
            cnt_r   <= cnt_r - 16'd1;
            baud_en <= 1'b0;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: decodes host accesses into single RX pops / TX pushes,
// holds the baud divisor and drives the oversample strobe.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          CNT_W     = 4,
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    spart_bus_if.slave        bus,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_empty,
    input  logic [CNT_W-1:0]  rx_count,
    output logic              rx_pop,
    input  logic              tx_full,
    input  logic [CNT_W-1:0]  tx_count,
    output logic              tx_push,
    output logic [DATA_W-1:0] tx_data,
    output logic              baud_en,
    output logic              rda,
    output logic              tbr
);

    bus_state_t        state_r, state_nxt_s;
    logic              start_s;
    logic              iorw_r;
    logic [DATA_W-1:0] dout_r, dout_nxt_s;
    logic              rx_pop_s;
    logic              tx_push_r, tx_push_nxt_s;
    logic [DATA_W-1:0] tx_data_r, tx_data_nxt_s;
    logic [15:0]       div_r, div_nxt_s;
    logic              div_load_s;

    // Access FSM: one action on the IDLE->HOLD transition, then wait for iocs to drop.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.iocs) begin
                    state_nxt_s = HOLD;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (bus.iocs) state_nxt_s = HOLD;
                else          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Register decode; rx_pop fires in the access cycle so the FWFT head is consumed with the capture.
    always_comb begin
        dout_nxt_s    = dout_r;
        rx_pop_s      = 1'b0;
        tx_push_nxt_s = 1'b0;
        tx_data_nxt_s = tx_data_r;
        div_nxt_s     = div_r;
        div_load_s    = 1'b0;
        if (start_s && bus.iorw) begin
            case (ioaddr_t'(bus.ioaddr))
                ADDR_DATA: begin
                    if (!rx_empty) begin
                        dout_nxt_s = rx_data;
                        rx_pop_s   = 1'b1;
                    end else begin
                        dout_nxt_s = {DATA_W{1'b0}};
                    end
                end
                ADDR_STATUS: dout_nxt_s = DATA_W'({calc_tx_free(tx_count), rx_count});
                ADDR_DBL:    dout_nxt_s = div_r[7:0];
                ADDR_DBH:    dout_nxt_s = div_r[15:8];
                default:     dout_nxt_s = dout_r;
            endcase
        end else if (start_s) begin
            case (ioaddr_t'(bus.ioaddr))
                ADDR_DATA: begin
                    if (!tx_full) begin
                        tx_push_nxt_s = 1'b1;
                        tx_data_nxt_s = bus.databus_in;
                    end else begin
                        tx_push_nxt_s = 1'b0;
                    end
                end
                ADDR_DBL: begin
                    div_nxt_s  = {div_r[15:8], bus.databus_in};
                    div_load_s = 1'b1;
                end
                ADDR_DBH: begin
                    div_nxt_s  = {bus.databus_in, div_r[7:0]};
                    div_load_s = 1'b1;
                end
                default: div_load_s = 1'b0;
            endcase
        end else begin
            dout_nxt_s = dout_r;
        end
    end

    // State, latched direction, read data, TX strobe/data and divisor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            iorw_r    <= 1'b0;
            dout_r    <= {DATA_W{1'b0}};
            tx_push_r <= 1'b0;
            tx_data_r <= {DATA_W{1'b0}};
            div_r     <= DIV_RESET;
        end else begin
            state_r   <= state_nxt_s;
            iorw_r    <= start_s ? bus.iorw : iorw_r;
            dout_r    <= dout_nxt_s;
            tx_push_r <= tx_push_nxt_s;
            tx_data_r <= tx_data_nxt_s;
            div_r     <= div_nxt_s;
        end
    end

    spart_baud_gen #(
        .DIV_RESET (DIV_RESET)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (div_nxt_s),
        .load    (div_load_s),
        .baud_en (baud_en)
    );

    assign bus.databus_out = dout_r;
    assign bus.databus_oe  = (state_r == HOLD) & bus.iocs & iorw_r;
    assign rx_pop          = rx_pop_s;
    assign tx_push         = tx_push_r;
    assign tx_data         = tx_data_r;
    assign rda             = ~rx_empty;
    assign tbr             = ~tx_full;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: reset state, baud timing, divisor access,
// RX pops, TX pushes, status read and reset during an access.
module tb_spart_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [3:0] rx_count;
    logic       rx_pop;
    logic       tx_full;
    logic [3:0] tx_count;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       baud_en;
    logic       rda;
    logic       tbr;

    int n_total = 0;
    int n_bad   = 0;
    int pop_cnt = 0;
    int push_cnt = 0;

    // Small RX FIFO model: fixed contents, rx_avail entries visible, rx_rd advanced by pops.
    logic [7:0] rx_mem [0:3] = '{8'hA5, 8'h3C, 8'h11, 8'h22};
    logic [3:0] rx_rd    = 4'd0;
    logic [3:0] rx_avail = 4'd2;

    spart_bus_if #(.DATA_W(8)) bus ();

    spart_bus_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_count (rx_count),
        .rx_pop   (rx_pop),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .tx_push  (tx_push),
        .tx_data  (tx_data),
        .baud_en  (baud_en),
        .rda      (rda),
        .tbr      (tbr)
    );

    always #5 clk = ~clk;

    assign rx_data  = rx_mem[rx_rd[1:0]];
    assign rx_empty = (rx_rd >= rx_avail);
    assign rx_count = rx_avail - rx_rd;

    // Strobe counters and FIFO pointer, sampled with pre-edge values.
    always @(posedge clk) begin
        if (rx_pop) begin
            pop_cnt = pop_cnt + 1;
            rx_rd <= rx_rd + 4'd1;
        end
        if (tx_push) push_cnt = push_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic bus_op(input logic rw, input logic [1:0] a, input logic [7:0] d,
                          input int hold, output logic [7:0] rd, output logic oe);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = rw; bus.ioaddr = a; bus.databus_in = d;
        @(negedge clk);
        rd = bus.databus_out;
        oe = bus.databus_oe;
        repeat (hold - 1) @(negedge clk);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    task automatic wait_baud(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n = n + 1;
        end while (!baud_en && n < 1000);
    endtask

    logic [7:0] rd;
    logic       oe;
    int         n, first, p0, t0;

    initial begin
        rst_n = 1'b0;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.databus_in = 8'h00;
        tx_full = 1'b0; tx_count = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.databus_out, 8'h00);
        check("rst_oe", bus.databus_oe, 1'b0);
        check("rst_pop", rx_pop, 1'b0);
        check("rst_push", tx_push, 1'b0);
        check("rst_txdata", tx_data, 8'h00);
        check("rst_baud", baud_en, 1'b0);
        rst_n = 1'b1;

        wait_baud(n);
        check("baud_first", n, 326);
        wait_baud(n);
        check("baud_period", n, 326);

        bus_op(1'b0, 2'b10, 8'h03, 2, rd, oe);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b11; bus.databus_in = 8'h00;
        @(posedge clk); #1;
        check("dbh_no_pulse", baud_en, 1'b0);
        first = 0;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2) bus.iocs = 1'b0;
            if (baud_en) begin
                first = k;
                break;
            end
        end
        check("dbh_first_pulse", first, 5);
        wait_baud(n);
        check("div3_period", n, 4);
        bus_op(1'b1, 2'b10, 8'h00, 4, rd, oe);
        check("dbl_readback", rd, 8'h03);
        check("dbl_oe", oe, 1'b1);

        check("rda_before", rda, 1'b1);
        p0 = pop_cnt;
        bus_op(1'b1, 2'b00, 8'h00, 4, rd, oe);
        check("rx_first", rd, 8'hA5);
        check("rx_first_oe", oe, 1'b1);
        bus_op(1'b1, 2'b00, 8'h00, 4, rd, oe);
        check("rx_second", rd, 8'h3C);
        #1;
        check("rx_pops", pop_cnt - p0, 2);
        check("rda_after", rda, 1'b0);
        check("oe_released", bus.databus_oe, 1'b0);

        p0 = pop_cnt;
        bus_op(1'b1, 2'b00, 8'h00, 3, rd, oe);
        check("rx_empty_data", rd, 8'h00);
        check("rx_empty_nopop", pop_cnt - p0, 0);

        t0 = push_cnt;
        bus_op(1'b0, 2'b00, 8'h5A, 3, rd, oe);
        check("tx_write_oe", oe, 1'b0);
        check("tx_push_once", push_cnt - t0, 1);
        check("tx_data_val", tx_data, 8'h5A);
        tx_full = 1'b1;
        #1;
        check("tbr_full", tbr, 1'b0);
        t0 = push_cnt;
        bus_op(1'b0, 2'b00, 8'h77, 3, rd, oe);
        @(negedge clk);
        check("tx_full_nopush", push_cnt - t0, 0);
        check("tx_full_data", tx_data, 8'h5A);
        tx_full = 1'b0;

        tx_count = 4'd3;
        rx_avail = 4'd4;
        bus_op(1'b1, 2'b01, 8'h00, 2, rd, oe);
        check("status", rd, 8'h52);

        bus_op(1'b0, 2'b10, 8'h00, 2, rd, oe);
        bus_op(1'b0, 2'b11, 8'h00, 2, rd, oe);
        repeat (2) @(negedge clk);
        check("div0_baud_a", baud_en, 1'b1);
        @(negedge clk);
        check("div0_baud_b", baud_en, 1'b1);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b01;
        @(negedge clk);
        check("hold_oe", bus.databus_oe, 1'b1);
        check("hold_dout", bus.databus_out, 8'h52);
        rst_n = 1'b0;
        #1;
        check("midrst_oe", bus.databus_oe, 1'b0);
        check("midrst_dout", bus.databus_out, 8'h00);
        check("midrst_baud", baud_en, 1'b0);
        check("midrst_pop", rx_pop, 1'b0);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_baud(n);
        check("post_rst_first", n, 326);
        wait_baud(n);
        check("post_rst_period", n, 326);
        bus_op(1'b1, 2'b10, 8'h00, 2, rd, oe);
        check("post_rst_dbl", rd, 8'h45);
        bus_op(1'b1, 2'b11, 8'h00, 2, rd, oe);
        check("post_rst_dbh", rd, 8'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
